// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer memory command/response bus between the arbiter (master)
// and the single-port memory (slave). Read data returns in issue order.
interface vga_fb_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 16
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: shares one memory port between the display fetch
// path (reads) and the draw engine (reads/writes). Display wins during
// active video, draw wins during vblank, and a starvation counter forces a
// draw grant after STARVE_LIMIT consecutive losses. A tag FIFO steers
// in-order read returns to their owner.
// Optional macro VGA_ARB_STATS_EN adds disp_stall_cnt / draw_force_cnt.
module vga_fb_arbiter #(
  parameter int AW              = 19,
  parameter int DW              = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                   pixel_clk,
  input  logic                   pixel_rst_n,
  input  logic                   vblank,
  input  logic                   disp_req,
  input  logic [AW-1:0]          disp_addr,
  output logic                   disp_gnt,
  output logic                   disp_rvalid,
  output logic [DW-1:0]          disp_rdata,
  input  logic                   draw_req,
  input  logic                   draw_we,
  input  logic [AW-1:0]          draw_addr,
  input  logic [DW-1:0]          draw_wdata,
  output logic                   draw_gnt,
  output logic                   draw_rvalid,
  output logic [DW-1:0]          draw_rdata,
  output logic                   rd_err,
  vga_fb_arbiter_if.master       mem
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [31:0]            disp_stall_cnt,
  output logic [15:0]            draw_force_cnt
`endif
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] TAG_FULL   = CW'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Tag FIFO: 0 = display read, 1 = draw read
  logic          tag_q [MAX_OUTSTANDING];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic [CW-1:0] tag_cnt;
  logic [SW-1:0] starve_cnt;

  logic slot_free;
  logic tag_push;
  logic tag_pop;
  logic tag_room;
  logic disp_elig;
  logic draw_elig;
  logic force_draw;
  logic rtn_tag_p0;

  // Grant decision: one winner per free slot, starvation rule first
  always_comb begin
    slot_free  = pixel_rst_n & (~mem.mem_req | mem.mem_ready);
    tag_pop    = mem.mem_rvalid & (tag_cnt != '0);
    // A pop in this cycle frees an entry, so a full FIFO can still accept
    tag_room   = (tag_cnt != TAG_FULL) | tag_pop;
    disp_elig  = disp_req & tag_room;
    draw_elig  = draw_req & (draw_we | tag_room);
    force_draw = slot_free & draw_elig & (starve_cnt == STARVE_MAX);
    rtn_tag_p0 = tag_q[tag_rd_ptr];
    disp_gnt   = 1'b0;
    draw_gnt   = 1'b0;
    if (slot_free) begin
      if (force_draw) begin
        draw_gnt = 1'b1;
      end else if (vblank) begin
        if (draw_elig)      draw_gnt = 1'b1;
        else if (disp_elig) disp_gnt = 1'b1;
      end else begin
        if (disp_elig)      disp_gnt = 1'b1;
        else if (draw_elig) draw_gnt = 1'b1;
      end
    end
    tag_push = disp_gnt | (draw_gnt & ~draw_we);
  end

  // Tag storage; contents are meaningless until the count covers them
  always_ff @(posedge pixel_clk) begin
    if (tag_push) tag_q[tag_wr_ptr] <= draw_gnt;
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + 1'b1;
      if (tag_push && !tag_pop)      tag_cnt <= tag_cnt + 1'b1;
      else if (!tag_push && tag_pop) tag_cnt <= tag_cnt - 1'b1;
    end
  end

  // Starvation counter: consecutive draw losses to display, saturating
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      starve_cnt <= '0;
    end else if (!draw_req || draw_gnt) begin
      starve_cnt <= '0;
    end else if (disp_gnt && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // ---- grant -> memory command register (1-cycle latency, held on stall)
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else if (slot_free) begin
      mem.mem_req <= disp_gnt | draw_gnt;
      if (draw_gnt) begin
        mem.mem_we    <= draw_we;
        mem.mem_addr  <= draw_addr;
        mem.mem_wdata <= draw_wdata;
      end else if (disp_gnt) begin
        mem.mem_we    <= 1'b0;
        mem.mem_addr  <= disp_addr;
      end
    end
  end

  // ---- memory return -> requester (1-cycle registered), sticky orphan error
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      disp_rvalid <= 1'b0;
      draw_rvalid <= 1'b0;
      disp_rdata  <= '0;
      draw_rdata  <= '0;
      rd_err      <= 1'b0;
    end else begin
      disp_rvalid <= tag_pop & ~rtn_tag_p0;
      draw_rvalid <= tag_pop & rtn_tag_p0;
      if (mem.mem_rvalid) begin
        disp_rdata <= mem.mem_rdata;
        draw_rdata <= mem.mem_rdata;
      end
      if (mem.mem_rvalid && tag_cnt == '0) rd_err <= 1'b1;
    end
  end

`ifdef VGA_ARB_STATS_EN
  // Saturating statistics: display stalls in active video, forced draw wins
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      disp_stall_cnt <= '0;
      draw_force_cnt <= '0;
    end else begin
      if (disp_req && !disp_gnt && !vblank && !(&disp_stall_cnt))
        disp_stall_cnt <= disp_stall_cnt + 1'b1;
      if (force_draw && !(&draw_force_cnt))
        draw_force_cnt <= draw_force_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed phases followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int MO = 4;
  localparam int SL = 8;

  logic          pixel_clk = 1'b0;
  logic          pixel_rst_n = 1'b0;
  logic          vblank = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_gnt, disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          draw_req = 1'b0;
  logic          draw_we = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic [DW-1:0] draw_wdata = '0;
  logic          draw_gnt, draw_rvalid;
  logic [DW-1:0] draw_rdata;
  logic          rd_err;
`ifdef VGA_ARB_STATS_EN
  logic [31:0]   disp_stall_cnt;
  logic [15:0]   draw_force_cnt;
`endif

  always #5 pixel_clk = ~pixel_clk;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

  vga_fb_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MO), .STARVE_LIMIT(SL)) dut (
    .pixel_clk   (pixel_clk),
    .pixel_rst_n (pixel_rst_n),
    .vblank      (vblank),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .draw_req    (draw_req),
    .draw_we     (draw_we),
    .draw_addr   (draw_addr),
    .draw_wdata  (draw_wdata),
    .draw_gnt    (draw_gnt),
    .draw_rvalid (draw_rvalid),
    .draw_rdata  (draw_rdata),
    .rd_err      (rd_err),
    .mem         (mem_bus)
`ifdef VGA_ARB_STATS_EN
    ,
    .disp_stall_cnt (disp_stall_cnt),
    .draw_force_cnt (draw_force_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int            m_starve;
  bit            m_tags[$];
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_dv, m_wv;
  logic [DW-1:0] m_rdata;
  logic          m_err;
  logic [DW-1:0] pend[$];
  bit            g_last_d, g_last_w;
  int            g_disp, g_draw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_tags.delete();
    pend.delete();
    m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
    m_dv = 1'b0; m_wv = 1'b0; m_rdata = '0; m_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, "_disp_gnt"},    64'(disp_gnt), 64'd0);
    chk({ph, "_draw_gnt"},    64'(draw_gnt), 64'd0);
    chk({ph, "_disp_rvalid"}, 64'(disp_rvalid), 64'd0);
    chk({ph, "_draw_rvalid"}, 64'(draw_rvalid), 64'd0);
    chk({ph, "_disp_rdata"},  64'(disp_rdata), 64'd0);
    chk({ph, "_draw_rdata"},  64'(draw_rdata), 64'd0);
    chk({ph, "_mem_req"},     64'(mem_bus.mem_req), 64'd0);
    chk({ph, "_mem_we"},      64'(mem_bus.mem_we), 64'd0);
    chk({ph, "_mem_addr"},    64'(mem_bus.mem_addr), 64'd0);
    chk({ph, "_mem_wdata"},   64'(mem_bus.mem_wdata), 64'd0);
    chk({ph, "_rd_err"},      64'(rd_err), 64'd0);
  endtask

  // Called at a falling edge with requests still held to see grants gated off
  task automatic do_reset();
    pixel_rst_n = 1'b0;
    #1;
    chk_all_zero("rst_a");
    model_reset();
    repeat (2) @(negedge pixel_clk);
    chk_all_zero("rst_b");
    pixel_rst_n = 1'b1;
  endtask

  // Drive memory return from the pending read list with probability pct
  task automatic mem_auto(input int pct);
    if (pend.size() > 0 && int'($urandom_range(99)) < pct) begin
      mem_bus.mem_rvalid = 1'b1;
      mem_bus.mem_rdata  = pend.pop_front();
    end else begin
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = DW'($urandom);
    end
  endtask

  // One clock: inputs already applied at the falling edge; check, then advance model
  task automatic cyc();
    bit slot, pop, room, de, we_e, gd, gw, owner;
    #1;
    slot = !m_req || mem_bus.mem_ready;
    pop  = mem_bus.mem_rvalid && m_tags.size() > 0;
    room = (m_tags.size() < MO) || pop;
    de   = disp_req && room;
    we_e = draw_req && (draw_we || room);
    gd = 1'b0; gw = 1'b0;
    if (slot) begin
      if (m_starve == SL && we_e) gw = 1'b1;
      else if (vblank) begin
        if (we_e) gw = 1'b1; else if (de) gd = 1'b1;
      end else begin
        if (de) gd = 1'b1; else if (we_e) gw = 1'b1;
      end
    end
    chk("disp_gnt", 64'(disp_gnt), 64'(gd));
    chk("draw_gnt", 64'(draw_gnt), 64'(gw));
    chk("mem_req", 64'(mem_bus.mem_req), 64'(m_req));
    if (m_req) begin
      chk("mem_addr", 64'(mem_bus.mem_addr), 64'(m_addr));
      chk("mem_we", 64'(mem_bus.mem_we), 64'(m_we));
      if (m_we) chk("mem_wdata", 64'(mem_bus.mem_wdata), 64'(m_wdata));
    end
    chk("disp_rvalid", 64'(disp_rvalid), 64'(m_dv));
    chk("draw_rvalid", 64'(draw_rvalid), 64'(m_wv));
    if (m_dv || m_wv) begin
      chk("disp_rdata", 64'(disp_rdata), 64'(m_rdata));
      chk("draw_rdata", 64'(draw_rdata), 64'(m_rdata));
    end
    chk("rd_err", 64'(rd_err), 64'(m_err));
    g_last_d = disp_gnt;
    g_last_w = draw_gnt;
    if (disp_gnt) g_disp++;
    if (draw_gnt) g_draw++;
    // memory side: an accepted read will come back later
    if (m_req && mem_bus.mem_ready && !m_we) pend.push_back(DW'($urandom));
    // advance reference model to the next edge
    m_dv = 1'b0; m_wv = 1'b0;
    if (mem_bus.mem_rvalid) begin
      m_rdata = mem_bus.mem_rdata;
      if (m_tags.size() > 0) begin
        owner = m_tags.pop_front();
        m_dv = !owner;
        m_wv = owner;
      end else begin
        m_err = 1'b1;
      end
    end
    if (gd) m_tags.push_back(1'b0);
    else if (gw && !draw_we) m_tags.push_back(1'b1);
    if (gw || !draw_req) m_starve = 0;
    else if (gd && m_starve < SL) m_starve++;
    if (slot) begin
      m_req = gd || gw;
      if (gw) begin
        m_we = draw_we; m_addr = draw_addr; m_wdata = draw_wdata;
      end else if (gd) begin
        m_we = 1'b0; m_addr = disp_addr;
      end
    end
    @(negedge pixel_clk);
  endtask

  task automatic drain(input int n);
    disp_req = 1'b0; draw_req = 1'b0; mem_bus.mem_ready = 1'b1;
    repeat (n) begin mem_auto(100); cyc(); end
    mem_bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata = '0;
    model_reset();
    @(negedge pixel_clk);
    disp_req = 1'b1;
    do_reset();

    // Phase 1: active video, both reading -> 8 display grants then 1 forced draw
    vblank = 1'b0; disp_req = 1'b1; draw_req = 1'b1; draw_we = 1'b0;
    disp_addr = AW'($urandom); draw_addr = AW'($urandom);
    mem_bus.mem_ready = 1'b1;
    g_disp = 0; g_draw = 0;
    repeat (27) begin
      mem_auto(100);
      cyc();
      if (g_last_d) disp_addr = AW'($urandom);
      if (g_last_w) draw_addr = AW'($urandom);
    end
    chk("p1_disp_grants", 64'(g_disp), 64'd24);
    chk("p1_draw_grants", 64'(g_draw), 64'd3);
    drain(6);

    // Phase 2: vblank, draw writes win every cycle
    vblank = 1'b1; disp_req = 1'b1; draw_req = 1'b1; draw_we = 1'b1;
    g_disp = 0; g_draw = 0;
    repeat (10) begin
      draw_addr = AW'($urandom); draw_wdata = DW'($urandom);
      mem_auto(100);
      cyc();
    end
    chk("p2_draw_grants", 64'(g_draw), 64'd10);
    chk("p2_disp_grants", 64'(g_disp), 64'd0);
    vblank = 1'b0;
    drain(6);

    // Phase 3: memory back-pressure for 5 cycles
    draw_req = 1'b1; draw_we = 1'b1;
    draw_addr = AW'($urandom); draw_wdata = DW'($urandom);
    cyc();
    draw_addr = AW'($urandom); draw_wdata = DW'($urandom);
    mem_bus.mem_ready = 1'b0;
    repeat (5) cyc();
    mem_bus.mem_ready = 1'b1;
    cyc();
    draw_req = 1'b0;
    cyc();

    // Phase 4: fill outstanding reads, writes still pass, pop reopens display
    mem_bus.mem_rvalid = 1'b0;
    disp_req = 1'b1;
    repeat (4) begin disp_addr = AW'($urandom); cyc(); end
    draw_req = 1'b1; draw_we = 1'b1;
    repeat (3) begin
      draw_addr = AW'($urandom); draw_wdata = DW'($urandom);
      cyc();
    end
    draw_req = 1'b0;
    mem_auto(100);
    cyc();
    mem_bus.mem_rvalid = 1'b0;
    disp_addr = AW'($urandom);
    cyc();
    drain(8);

    // Phase 5: interleaved reads routed in order
    disp_req = 1'b1; disp_addr = 19'h00100; cyc();
    disp_req = 1'b0; draw_req = 1'b1; draw_we = 1'b0; draw_addr = 19'h00200; cyc();
    draw_req = 1'b0; disp_req = 1'b1; disp_addr = 19'h00300; cyc();
    disp_req = 1'b0;
    repeat (2) cyc();
    pend.delete();
    mem_bus.mem_rvalid = 1'b1;
    mem_bus.mem_rdata = 16'h1111; cyc();
    mem_bus.mem_rdata = 16'h2222; cyc();
    mem_bus.mem_rdata = 16'h3333; cyc();
    mem_bus.mem_rvalid = 1'b0;
    repeat (2) cyc();

    // Phase 6: randomized traffic
    disp_req = 1'b0; draw_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(19) == 0) vblank = ~vblank;
      mem_bus.mem_ready = ($urandom_range(3) != 0);
      mem_auto(60);
      cyc();
      if (!disp_req || g_last_d) begin
        disp_req = $urandom_range(1) == 1;
        disp_addr = AW'($urandom);
      end
      if (!draw_req || g_last_w) begin
        draw_req = $urandom_range(1) == 1;
        draw_we = $urandom_range(1) == 1;
        draw_addr = AW'($urandom);
        draw_wdata = DW'($urandom);
      end
    end
    vblank = 1'b0;
    drain(16);

    // Phase 7: reset with reads in flight, then an orphan return
    disp_req = 1'b1;
    repeat (3) begin disp_addr = AW'($urandom); cyc(); end
    do_reset();
    disp_req = 1'b0;
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
    cyc();
    mem_bus.mem_rvalid = 1'b0;
    repeat (2) cyc();
    chk("p7_rd_err_sticky", 64'(rd_err), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
